// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode encodings, channel config type and helpers for pwm_divider
package pwm_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PWM    = 1'b1;

  // Config fields are stored at a fixed maximum width; channels zero-extend
  // their CNT_WIDTH values into it and the unused upper bits stay constant.
  localparam int CFG_WIDTH_MAX = 32;

  typedef struct packed {
    logic [CFG_WIDTH_MAX-1:0] period;
    logic [CFG_WIDTH_MAX-1:0] duty;
  } pwm_cfg_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one divider/PWM channel: counter, active/shadow config, pending flag, output
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int          CNT_WIDTH  = 25,
  parameter int unsigned PERIOD_RST = 24_999_999,
  parameter int unsigned DUTY_RST   = 12_500_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 advance,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_duty,
  output logic                 pending,
  output logic                 out,
  output logic                 wrap
);

  localparam pwm_cfg_t RST_CFG = '{period: PERIOD_RST, duty: DUTY_RST};

  logic [CNT_WIDTH-1:0]     cnt;
  logic [CNT_WIDTH-1:0]     cnt_next;
  pwm_cfg_t                 act_cfg;
  pwm_cfg_t                 shd_cfg;
  pwm_cfg_t                 new_cfg;
  logic [CFG_WIDTH_MAX-1:0] eff_duty;
  logic                     wrap_hit;
  logic                     apply;

  // Next count, wrap detection and the shadow->active hand-over point.
  // On the applying wrap the new duty already shapes the first cycle.
  always_comb begin
    new_cfg.period = CFG_WIDTH_MAX'(cfg_period);
    new_cfg.duty   = CFG_WIDTH_MAX'(cfg_duty);
    wrap_hit       = (CFG_WIDTH_MAX'(cnt) == act_cfg.period);
    cnt_next       = wrap_hit ? '0 : cnt + CNT_WIDTH'(1);
    apply          = pending && (!en || (advance && wrap_hit));
    eff_duty       = apply ? shd_cfg.duty : act_cfg.duty;
  end

  // Config registers, counter and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt     <= '0;
      out     <= 1'b0;
      wrap    <= 1'b0;
      pending <= 1'b0;
      act_cfg <= RST_CFG;
      shd_cfg <= RST_CFG;
    end else begin
      if (apply) begin
        act_cfg <= shd_cfg;
      end
      // A request landing on the applying edge becomes the next pending one.
      if (load) begin
        shd_cfg <= new_cfg;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
      if (!en) begin
        cnt  <= '0;
        out  <= 1'b0;
        wrap <= 1'b0;
      end else if (advance) begin
        cnt  <= cnt_next;
        wrap <= wrap_hit;
        unique case (mode)
          MODE_TOGGLE: out <= out ^ wrap_hit;
          MODE_PWM:    out <= (CFG_WIDTH_MAX'(cnt_next) < eff_duty);
        endcase
      end else begin
        wrap <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_divider.sv
// rtl/pwm_divider.sv - multi-channel clock divider / PWM top; optional shared prescaler under PWM_PRESCALE_EN
module pwm_divider
  import pwm_pkg::*;
#(
  parameter int          CH_NUM     = 4,
  parameter int          CNT_WIDTH  = 25,
  parameter int unsigned PERIOD_RST = 24_999_999,
  parameter int unsigned DUTY_RST   = 12_500_000,
  parameter int          PRESCALE   = 50
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic [CH_NUM-1:0]               en,
  input  logic [CH_NUM-1:0]               mode,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [clog2_min1(CH_NUM)-1:0]   cfg_ch,
  input  logic [CNT_WIDTH-1:0]            cfg_period,
  input  logic [CNT_WIDTH-1:0]            cfg_duty,
  output logic [CH_NUM-1:0]               out,
  output logic [CH_NUM-1:0]               wrap
);

  localparam int CH_W = clog2_min1(CH_NUM);

  logic              advance;
  logic [CH_NUM-1:0] pending;
  logic [CH_NUM-1:0] load;

`ifdef PWM_PRESCALE_EN
  localparam int PRE_W = clog2_min1(PRESCALE);

  logic [PRE_W-1:0] pre_cnt;

  assign advance = (pre_cnt == PRE_W'(PRESCALE - 1));

  // Free-running shared prescaler; channels advance on its terminal count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= advance ? '0 : pre_cnt + PRE_W'(1);
    end
  end
`else
  assign advance = 1'b1;
`endif

  // Ready reflects the addressed channel's pending flag; an address beyond
  // CH_NUM is accepted and discarded so the port never stalls.
  always_comb begin
    cfg_ready = 1'b1;
    load      = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pending[i];
      end
    end
    for (int i = 0; i < CH_NUM; i++) begin
      load[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pwm_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .PERIOD_RST (PERIOD_RST),
      .DUTY_RST   (DUTY_RST)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .advance    (advance),
      .en         (en[i]),
      .mode       (mode[i]),
      .load       (load[i]),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .pending    (pending[i]),
      .out        (out[i]),
      .wrap       (wrap[i])
    );
  end

endmodule
